// File: rtl/conv_line_buffer_if.sv
// Pixel-stream, frame-configuration and column-output bundle for conv_line_buffer.
// The master drives frames in and consumes columns; the slave is the line buffer.
interface conv_line_buffer_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned KERNEL_SIZE = 5,
  parameter int unsigned CW          = 7,
  parameter int unsigned HW          = 16
);
  logic                              start;
  logic [CW-1:0]                     img_width;
  logic [HW-1:0]                     img_height;
  logic                              in_valid;
  logic [DATA_WIDTH-1:0]             data_in;
  logic                              out_valid;
  logic [DATA_WIDTH*KERNEL_SIZE-1:0] data_out;
  logic [CW-1:0]                     out_col;
  logic [HW-1:0]                     out_row;
  logic                              busy;
  logic                              frame_done;

  modport master (
    output start, img_width, img_height, in_valid, data_in,
    input  out_valid, data_out, out_col, out_row, busy, frame_done
  );

  modport slave (
    input  start, img_width, img_height, in_valid, data_in,
    output out_valid, data_out, out_col, out_row, busy, frame_done
  );
endinterface

// File: rtl/conv_line_buffer.sv
// Runtime-sized line buffer: keeps the last KERNEL_SIZE-1 rows in circular line
// memories and emits one registered vertical pixel column per accepted pixel.
module conv_line_buffer #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned KERNEL_SIZE   = 5,
  parameter int unsigned MAX_IMG_WIDTH = 64,
  parameter int unsigned CW            = $clog2(MAX_IMG_WIDTH + 1),
  parameter int unsigned HW            = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  conv_line_buffer_if.slave  bus
);

  localparam int unsigned AW    = (MAX_IMG_WIDTH > 1) ? $clog2(MAX_IMG_WIDTH) : 1;
  localparam int unsigned LINES = KERNEL_SIZE - 1;
  localparam int unsigned OW    = DATA_WIDTH * KERNEL_SIZE;

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         width_q, col_cnt;
  logic [HW-1:0]         height_q, row_cnt;
  logic [DATA_WIDTH-1:0] line_mem [LINES][MAX_IMG_WIDTH];

  logic                  accept_c, wrap_c, last_c;
  logic [AW-1:0]         addr_c;
  logic [OW-1:0]         column_c;
  logic [CW-1:0]         width_clamp_c;
  logic [HW-1:0]         height_clamp_c;

  // Next state; a start pulse always wins and drops any pixel in the same cycle.
  always_comb begin
    state_d  = state_q;
    wrap_c   = (col_cnt == width_q - CW'(1));
    last_c   = wrap_c && (row_cnt == height_q - HW'(1));
    accept_c = bus.in_valid && (state_q != IDLE) && !bus.start;
    if (bus.start) begin
      state_d = FILL;
    end else if (accept_c) begin
      if (last_c) begin
        state_d = IDLE;
      end else if ((state_q == FILL) && wrap_c && (row_cnt == HW'(KERNEL_SIZE - 2))) begin
        state_d = STREAM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    width_clamp_c  = bus.img_width;
    height_clamp_c = bus.img_height;
    if ((bus.img_width == '0) || (bus.img_width > CW'(MAX_IMG_WIDTH)))
      width_clamp_c = CW'(MAX_IMG_WIDTH);
    if (bus.img_height == '0)
      height_clamp_c = HW'(1);
  end

  // Column from pre-write memory contents: top slice is the live pixel.
  always_comb begin
    addr_c                        = AW'(col_cnt);
    column_c                      = '0;
    column_c[OW-1 -: DATA_WIDTH]  = bus.data_in;
    for (int j = 0; j < int'(LINES); j++)
      column_c[j*DATA_WIDTH +: DATA_WIDTH] = line_mem[int'(LINES) - 1 - j][addr_c];
  end

  // Line memories are intentionally unreset; FILL keeps stale rows invisible.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      for (int i = int'(LINES) - 1; i > 0; i--)
        line_mem[i][addr_c] <= line_mem[i-1][addr_c];
      line_mem[0][addr_c] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q  <= CW'(MAX_IMG_WIDTH);
      height_q <= HW'(1);
      col_cnt  <= '0;
      row_cnt  <= '0;
    end else if (bus.start) begin
      width_q  <= width_clamp_c;
      height_q <= height_clamp_c;
      col_cnt  <= '0;
      row_cnt  <= '0;
    end else if (accept_c) begin
      if (last_c) begin
        col_cnt <= '0;
        row_cnt <= '0;
      end else if (wrap_c) begin
        col_cnt <= '0;
        row_cnt <= row_cnt + HW'(1);
      end else begin
        col_cnt <= col_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.data_out   <= '0;
      bus.out_col    <= '0;
      bus.out_row    <= '0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.out_valid  <= accept_c && (state_q == STREAM);
      bus.frame_done <= accept_c && last_c;
      bus.busy       <= (state_d != IDLE);
      if (accept_c && (state_q == STREAM)) begin
        bus.data_out <= column_c;
        bus.out_col  <= col_cnt;
        bus.out_row  <= row_cnt;
      end
    end
  end

endmodule

// File: tb/tb_conv_line_buffer.sv
// Randomized bench for conv_line_buffer against an image-coordinate reference model.
module tb_conv_line_buffer;

  localparam int unsigned DW   = 16;
  localparam int unsigned K    = 3;
  localparam int unsigned MAXW = 8;
  localparam int unsigned CW   = 4;
  localparam int unsigned HW   = 16;

  logic clk;
  logic rst_n;

  conv_line_buffer_if #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .CW(CW), .HW(HW)) bus ();

  conv_line_buffer #(
    .DATA_WIDTH(DW), .KERNEL_SIZE(K), .MAX_IMG_WIDTH(MAXW), .CW(CW), .HW(HW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  int n_cols;
  int n_done;

  // Reference model: the frame as a 2-D image indexed by (row, col).
  bit             m_active;
  int             m_w, m_h, m_r, m_c;
  logic [DW-1:0]  img [16][MAXW];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit st, input bit vld, input logic [DW-1:0] d,
                      input int w, input int h);
    logic            exp_valid, exp_done;
    logic [DW*K-1:0] exp_data;
    int              exp_col, exp_row;
    bus.start      = st;
    bus.in_valid   = vld;
    bus.data_in    = d;
    bus.img_width  = CW'(w);
    bus.img_height = HW'(h);
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    exp_data  = '0;
    exp_col   = 0;
    exp_row   = 0;
    if (st) begin
      m_active = 1'b1;
      m_w = (w == 0 || w > int'(MAXW)) ? int'(MAXW) : w;
      m_h = (h == 0) ? 1 : h;
      m_r = 0;
      m_c = 0;
    end else if (m_active && vld) begin
      img[m_r][m_c] = d;
      if (m_r >= int'(K) - 1) begin
        exp_valid = 1'b1;
        exp_col   = m_c;
        exp_row   = m_r;
        for (int j = 0; j < int'(K); j++)
          exp_data[j*DW +: DW] = img[m_r - (int'(K) - 1) + j][m_c];
      end
      if (m_c == m_w - 1 && m_r == m_h - 1) begin
        exp_done = 1'b1;
        m_active = 1'b0;
      end else if (m_c == m_w - 1) begin
        m_c = 0;
        m_r++;
      end else begin
        m_c++;
      end
    end
    @(posedge clk);
    #1;
    n_cols += int'(bus.out_valid);
    n_done += int'(bus.frame_done);
    check("out_valid",  64'(bus.out_valid),  64'(exp_valid));
    check("frame_done", 64'(bus.frame_done), 64'(exp_done));
    check("busy",       64'(bus.busy),       64'(m_active));
    if (exp_valid) begin
      check("data_out", 64'(bus.data_out), 64'(exp_data));
      check("out_col",  64'(bus.out_col),  64'(exp_col));
      check("out_row",  64'(bus.out_row),  64'(exp_row));
    end
  endtask

  // Streams one frame; returns early (before driving) at (ar, ac) when ar >= 0.
  task automatic run_frame(input int w, input int h, input int pct, input bit rnd,
                           input int ar, input int ac, input bit start_vld);
    logic [DW-1:0] d;
    bit            vld;
    n_cols = 0;
    n_done = 0;
    step(1'b1, start_vld, DW'($urandom), w, h);
    for (int cyc = 0; cyc < 4000 && m_active; cyc++) begin
      if (ar >= 0 && m_r == ar && m_c == ac) return;
      vld = (int'($urandom_range(99)) < pct);
      d   = rnd ? DW'($urandom) : DW'(m_r * 16 + m_c);
      step(1'b0, vld, d, w, h);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, 64'(bus.out_valid),  64'(0));
    check({tag, "_data"},  64'(bus.data_out),   64'(0));
    check({tag, "_col"},   64'(bus.out_col),    64'(0));
    check({tag, "_row"},   64'(bus.out_row),    64'(0));
    check({tag, "_busy"},  64'(bus.busy),       64'(0));
    check({tag, "_done"},  64'(bus.frame_done), 64'(0));
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_cols = 0; n_done = 0;
    m_active = 1'b0; m_w = 0; m_h = 0; m_r = 0; m_c = 0;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.data_in = '0;
    bus.img_width = '0; bus.img_height = '0;
    rst_n = 1'b0;
    #12;
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Inputs ignored in IDLE
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, DW'($urandom), 4, 4);

    // Basic frame, continuous valid, pixel = row*16+col
    run_frame(4, 4, 100, 1'b0, -1, 0, 1'b0);
    check("basic_cols", 64'(n_cols), 64'(8));
    check("basic_done", 64'(n_done), 64'(1));
    step(1'b0, 1'b0, '0, 4, 4);

    // Same frame with bubbles
    run_frame(4, 4, 50, 1'b0, -1, 0, 1'b0);
    check("bubble_cols", 64'(n_cols), 64'(8));

    // Back-to-back frames, width 4 then 7
    run_frame(4, 4, 100, 1'b1, -1, 0, 1'b0);
    run_frame(7, 4, 70, 1'b1, -1, 0, 1'b0);
    check("w7_cols", 64'(n_cols), 64'(14));

    // Abort at row 2 col 1 with a pixel presented alongside start
    run_frame(4, 4, 100, 1'b0, 2, 1, 1'b0);
    run_frame(4, 4, 100, 1'b0, -1, 0, 1'b1);
    check("abort_cols", 64'(n_cols), 64'(8));
    check("abort_done", 64'(n_done), 64'(1));

    // Width clamping: 0 and oversize both mean MAX_IMG_WIDTH
    run_frame(0, 3, 80, 1'b1, -1, 0, 1'b0);
    check("w0_cols", 64'(n_cols), 64'(MAXW));
    run_frame(12, 3, 100, 1'b1, -1, 0, 1'b0);
    check("w12_cols", 64'(n_cols), 64'(MAXW));

    // Frames shorter than the kernel
    run_frame(5, 2, 100, 1'b1, -1, 0, 1'b0);
    check("h2_cols", 64'(n_cols), 64'(0));
    check("h2_done", 64'(n_done), 64'(1));
    run_frame(3, 0, 100, 1'b1, -1, 0, 1'b0);
    check("h0_cols", 64'(n_cols), 64'(0));
    check("h0_done", 64'(n_done), 64'(1));

    // Single-pixel-wide image
    run_frame(1, 4, 60, 1'b1, -1, 0, 1'b0);
    check("w1_cols", 64'(n_cols), 64'(2));

    // Asynchronous reset mid-STREAM, no clock edge involved
    run_frame(4, 4, 100, 1'b1, 3, 1, 1'b0);
    check("pre_rst_valid", 64'(bus.out_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    m_active = 1'b0;
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, DW'($urandom), 4, 4);
    run_frame(4, 4, 100, 1'b0, -1, 0, 1'b0);
    check("post_rst_cols", 64'(n_cols), 64'(8));
    step(1'b0, 1'b0, '0, 4, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conv_line_buffer.md
# conv_line_buffer

Parametrised, runtime-configurable line buffer for the convolution datapath. It accepts a raster-order pixel stream with a valid qualifier and keeps the previous KERNEL_SIZE-1 image rows in circular line memories. For every accepted pixel it emits one vertical column of KERNEL_SIZE pixels, registered, for the downstream window/MAC stage. Image width and height are set per frame at run time, and the block suppresses output until the kernel column is fully populated.

## Interface
- DATA_WIDTH, 32, pixel width in bits
- KERNEL_SIZE, 5, rows per output column; legal range ≥2
- MAX_IMG_WIDTH, 64, line memory depth; maximum runtime width
- CW, $clog2(MAX_IMG_WIDTH+1), width of the img_width and out_col fields
- HW, 16, width of the img_height and out_row fields

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; latches img_width/img_height and begins a frame
- img_width  in  CW  pixels per row, sampled on start
- img_height  in  HW  rows per frame, sampled on start
- in_valid  in  1  data_in is valid this cycle
- data_in  in  DATA_WIDTH  pixel, raster order
- out_valid  out  1  data_out/out_col/out_row valid
- data_out  out  DATA_WIDTH*KERNEL_SIZE  column; top slice = current row (data_in), slice 0 = oldest row
- out_col  out  CW  column index of the emitted column
- out_row  out  HW  row index of data_in in the emitted column
- busy  out  1  frame in progress (FILL or STREAM)
- frame_done  out  1  one-cycle pulse after the last pixel of the frame is accepted

## Operation
- States: IDLE, FILL, STREAM.
- IDLE:
  - in_valid is ignored.
  - start latches the sizes, clears col_cnt/row_cnt, and moves to FILL. If KERNEL_SIZE-1 == 0 rows are needed it moves to STREAM instead (unreachable for legal K).
- Size clamping at start: img_width of 0 or >MAX_IMG_WIDTH latches as MAX_IMG_WIDTH. img_height of 0 latches as 1.
- Accepted pixel = in_valid while in FILL or STREAM. Per accepted pixel, at address col_cnt:
  - line[0][col] <= data_in
  - line[i][col] <= line[i-1][col] for i = 1..K-2, using the old values (shift-register semantics across rows)
  - Column formed from the pre-write contents: slice K-1 = data_in, slice j = line[K-2-j][col] for j = 0..K-2.
- Counters:
  - col_cnt increments per accepted pixel and wraps to 0 at width_q-1.
  - On wrap, row_cnt increments.
  - FILL → STREAM on the wrap that makes row_cnt == K-1.
- Output:
  - In STREAM, each accepted pixel produces out_valid next cycle, with data_out, out_col = col_cnt, out_row = row_cnt.
  - In FILL, out_valid stays 0. Stale memory contents from a previous frame are therefore never visible.
- End of frame: the accepted pixel at col = width_q-1, row = height_q-1 → IDLE, with frame_done pulsed next cycle.
- If height_q < K, the frame completes in FILL with no output, and frame_done still pulses.
- start while busy aborts the frame: counters clear, sizes re-latch, state → FILL. A pixel presented in the same cycle is dropped, and no frame_done is generated for the aborted frame.
- Line memories are not reset or cleared. They may map to distributed RAM: combinational read, synchronous write.

## Timing
- Latency: accepted pixel at edge N → out_valid/data_out at edge N+1. Throughput 1 column/cycle; no backpressure.
- in_valid gaps: counters and memory hold, and out_valid deasserts for each idle cycle.
- Reset values: out_valid 0, data_out 0, out_col 0, out_row 0, busy 0, frame_done 0. State IDLE, counters 0, latched sizes MAX_IMG_WIDTH/1.
- Reset asserted mid-frame: all of the above apply immediately (asynchronous). Memory contents are undefined afterwards, which is harmless because FILL masks them.
- busy is registered: 1 from the cycle after start until the cycle frame_done asserts.
- frame_done and the final out_valid assert in the same cycle.

## Test plan
- Basic frame, K=3, width 4, height 4, pixel = row*16+col, continuous valid:
  - No out_valid for rows 0–1.
  - First column at out_row 2, out_col 0 = {0x20, 0x10, 0x00} (top→bottom).
  - 8 columns in total.
  - frame_done coincides with the column {0x33, 0x23, 0x13}.
- Bubbles: same frame with in_valid toggled randomly → identical column sequence to the basic frame, out_valid exactly 1 cycle after each accepted pixel.
- Back-to-back frames with width 4 then width 7 on the same instance:
  - Second frame outputs contain no first-frame values.
  - Wrap occurs at col 6.
- Abort: start at row 2, col 1 of a frame, with in_valid high that cycle → pixel dropped, no frame_done, new frame behaves as in the basic frame.
- Edge sizes:
  - img_width 0 → wraps at MAX_IMG_WIDTH-1.
  - img_height 2 with K=3 → zero outputs, frame_done pulses once.
  - img_width 1 → one column per row.
- Async reset asserted mid-STREAM without a clock edge → outputs 0 immediately. After release, in_valid is ignored until start.
